// File: rtl/rv32_mmio_pkg.sv
// Shared definitions for the rv32 MMIO GPIO responder: register offsets, bit indices, bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_mmio_pkg;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] OFS_LED_OUT = 5'h00;
  localparam logic [4:0] OFS_LED_SET = 5'h04;
  localparam logic [4:0] OFS_LED_CLR = 5'h08;
  localparam logic [4:0] OFS_LED_TGL = 5'h0C;
  localparam logic [4:0] OFS_TIMER   = 5'h10;
  localparam logic [4:0] OFS_CTRL    = 5'h14;
  localparam logic [4:0] OFS_CMP     = 5'h18;
  localparam logic [4:0] OFS_STATUS  = 5'h1C;

  localparam logic [31:0] WINDOW_BYTES = 32'h20;

  // CTRL / STATUS bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTOBLINK = 1;
  localparam int STATUS_MATCH   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Expand per-byte write strobes into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/rv32_mmio_gpio_if.sv
// Load/store port between the priRV32 core (master) and an MMIO responder (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready for requests, rsp_valid/rsp_ready for responses.
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb, rsp_valid/rsp_ready/rsp_rdata/rsp_err.
interface rv32_mmio_gpio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32_mmio_timer.sv
// Free-running compare timer: counts while enabled, wraps to 0 after reaching CMP (period CMP+1).
// Latency: match is combinational on the current TIMER/CMP; register writes land on the next edge.
// Backpressure: none; a software write to TIMER overrides both the increment and the wrap.
// Ports: clk, rst_n, en, tmr_we/tmr_wdata, cmp_we/cmp_wdata -> timer, cmp, match.
module rv32_mmio_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        tmr_we,
  input  logic [31:0] tmr_wdata,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  output logic [31:0] timer,
  output logic [31:0] cmp,
  output logic        match
);

  logic [31:0] timer_q;
  logic [31:0] cmp_q;

  // High during the cycle whose closing edge performs the wrap
  assign match = en && (timer_q == cmp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (tmr_we) begin
      timer_q <= tmr_wdata;
    end else if (match) begin
      timer_q <= '0;
    end else if (en) begin
      timer_q <= timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= 32'hFFFF_FFFF;
    end else if (cmp_we) begin
      cmp_q <= cmp_wdata;
    end
  end

  assign timer = timer_q;
  assign cmp   = cmp_q;

endmodule

// File: rtl/rv32_mmio_gpio.sv
// MMIO responder for the priRV32 load/store port: LED set/clear/toggle regs plus a blink timer.
// Latency: one response per accepted request, rsp_valid the edge after acceptance.
// Backpressure: req_ready = !rsp_valid || rsp_ready; a stalled response holds rsp_* stable.
// Ports: clk, rst_n, bus (rv32_mmio_gpio_if.slave), led[LED_W-1:0].
module rv32_mmio_gpio
  import rv32_mmio_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR = 32'h1000_0000,
  parameter int unsigned      LED_W     = 8,
  parameter logic [LED_W-1:0] LED_RST   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32_mmio_gpio_if.slave  bus,
  output logic [LED_W-1:0] led
);

  req_t             req;
  rsp_t             rsp_d;
  rsp_t             rsp_q;
  logic             rsp_valid_q;
  logic             accept;
  logic [31:0]      offset;
  logic [4:0]       ofs;
  logic             dec_err;
  logic             wr;
  logic [31:0]      wmask;
  logic [31:0]      wdm;
  logic [31:0]      rdata_mux;
  logic [31:0]      led_ext;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_sw;
  logic [LED_W-1:0] led_d;
  logic             sw_led0;
  logic             ctrl_en_q;
  logic             ctrl_ab_q;
  logic             match_q;
  logic [31:0]      timer_val;
  logic [31:0]      cmp_val;
  logic             match_pulse;
  logic             tmr_we;
  logic             cmp_we;
  logic [31:0]      tmr_wdata;
  logic [31:0]      cmp_wdata;

  assign req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, wstrb: bus.req_wstrb};

  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of the window
  assign offset  = req.addr - BASE_ADDR;
  assign ofs     = offset[4:0];
  assign dec_err = (offset >= WINDOW_BYTES) || (req.addr[1:0] != 2'b00);

  // Only error-free stores with at least one lane enabled have side effects
  assign wr    = accept && req.we && !dec_err && (req.wstrb != 4'b0000);
  assign wmask = strb_mask(req.wstrb);
  assign wdm   = req.wdata & wmask;

  always_comb begin
    led_ext             = '0;
    led_ext[LED_W-1:0]  = led_q;
  end

  // Read mux uses current register values, i.e. before this edge's updates
  always_comb begin
    rdata_mux = '0;
    case (ofs)
      OFS_LED_OUT: rdata_mux = led_ext;
      OFS_TIMER:   rdata_mux = timer_val;
      OFS_CTRL: begin
        rdata_mux[CTRL_EN]        = ctrl_en_q;
        rdata_mux[CTRL_AUTOBLINK] = ctrl_ab_q;
      end
      OFS_CMP:     rdata_mux = cmp_val;
      OFS_STATUS:  rdata_mux[STATUS_MATCH] = match_q;
      default:     rdata_mux = '0;
    endcase
  end

  // Software LED update; sw_led0 flags that this store actually drives led[0],
  // in which case it wins over the autoblink toggle.
  always_comb begin
    led_sw  = led_q;
    sw_led0 = 1'b0;
    if (wr) begin
      case (ofs)
        OFS_LED_OUT: begin
          led_sw  = (led_q & ~wmask[LED_W-1:0]) | wdm[LED_W-1:0];
          sw_led0 = wmask[0];
        end
        OFS_LED_SET: begin
          led_sw  = led_q | wdm[LED_W-1:0];
          sw_led0 = wdm[0];
        end
        OFS_LED_CLR: begin
          led_sw  = led_q & ~wdm[LED_W-1:0];
          sw_led0 = wdm[0];
        end
        OFS_LED_TGL: begin
          led_sw  = led_q ^ wdm[LED_W-1:0];
          sw_led0 = wdm[0];
        end
        default: ;
      endcase
    end
    led_d = led_sw;
    if (ctrl_ab_q && match_pulse && !sw_led0) begin
      led_d[0] = ~led_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= LED_RST;
      ctrl_en_q <= 1'b0;
      ctrl_ab_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      led_q <= led_d;
      if (wr && (ofs == OFS_CTRL) && req.wstrb[0]) begin
        ctrl_en_q <= req.wdata[CTRL_EN];
        ctrl_ab_q <= req.wdata[CTRL_AUTOBLINK];
      end
      // Hardware set has priority over a same-edge W1C
      if (match_pulse) begin
        match_q <= 1'b1;
      end else if (wr && (ofs == OFS_STATUS) && wdm[STATUS_MATCH]) begin
        match_q <= 1'b0;
      end
    end
  end

  assign tmr_we    = wr && (ofs == OFS_TIMER);
  assign cmp_we    = wr && (ofs == OFS_CMP);
  assign tmr_wdata = (timer_val & ~wmask) | wdm;
  assign cmp_wdata = (cmp_val & ~wmask) | wdm;

  rv32_mmio_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ctrl_en_q),
    .tmr_we    (tmr_we),
    .tmr_wdata (tmr_wdata),
    .cmp_we    (cmp_we),
    .cmp_wdata (cmp_wdata),
    .timer     (timer_val),
    .cmp       (cmp_val),
    .match     (match_pulse)
  );

  always_comb begin
    rsp_d.err   = dec_err;
    rsp_d.rdata = (dec_err || req.we) ? 32'd0 : rdata_mux;
  end

  // Response register: loads on accept, clears when drained, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign led           = led_q;

endmodule

// File: tb/tb_rv32_mmio_gpio.sv
// Scoreboard bench for rv32_mmio_gpio: a per-cycle reference model predicts responses and LEDs.
// Latency: model prediction is pushed one cycle before the DUT presents the response.
// Backpressure: rsp_ready is driven always-1, random, or held low depending on the phase.
module tb_rv32_mmio_gpio;
  import rv32_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          LW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] led;

  rv32_mmio_gpio_if bus ();

  rv32_mmio_gpio #(.BASE_ADDR(BASE), .LED_W(LW), .LED_RST('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_mode = 2;   // 0: always ready, 1: random, 2: held low
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t expq[$];

  logic [31:0] last_rdata;
  logic        last_err;

  // Reference model state (mirrors the DUT state after the most recent edge)
  logic [LW-1:0] m_led;
  logic [31:0]   m_timer, m_cmp;
  logic          m_en, m_ab, m_match, m_pend;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_led = '0; m_timer = '0; m_cmp = 32'hFFFF_FFFF;
    m_en = 1'b0; m_ab = 1'b0; m_match = 1'b0; m_pend = 1'b0;
  endfunction

  // Predict what the coming rising edge does, from the register map rules
  function automatic void model_step();
    logic          acc, fire, bad, touch0, n_en, n_ab, n_match;
    logic [31:0]   off, mask, d, rv, n_timer, n_cmp;
    logic [LW-1:0] n_led, sw;
    exp_t          e;
    acc     = bus.req_valid && (!m_pend || bus.rsp_ready);
    fire    = m_en && (m_timer == m_cmp);
    n_timer = fire ? 32'd0 : (m_en ? m_timer + 32'd1 : m_timer);
    n_cmp   = m_cmp;
    n_en    = m_en;
    n_ab    = m_ab;
    n_match = m_match || fire;
    n_led   = m_led;
    if (m_ab && fire) n_led[0] = !m_led[0];
    if (acc) begin
      off  = bus.req_addr - BASE;
      bad  = (off > 32'd31) || (bus.req_addr[1:0] != 2'b00);
      mask = '0;
      for (int b = 0; b < 4; b++) if (bus.req_wstrb[b]) mask[8*b +: 8] = 8'hFF;
      d  = bus.req_wdata & mask;
      rv = '0;
      case (off)
        32'd0:  rv = 32'(m_led);
        32'd16: rv = m_timer;
        32'd20: rv = {30'd0, m_ab, m_en};
        32'd24: rv = m_cmp;
        32'd28: rv = {31'd0, m_match};
        default: rv = '0;
      endcase
      e.rdata = (bad || bus.req_we) ? 32'd0 : rv;
      e.err   = bad;
      expq.push_back(e);
      if (!bad && bus.req_we && (mask != 0)) begin
        sw = m_led; touch0 = 1'b0;
        case (off)
          32'd0:  begin sw = (m_led & ~mask[LW-1:0]) | d[LW-1:0]; touch0 = mask[0]; end
          32'd4:  begin sw = m_led | d[LW-1:0];  touch0 = d[0]; end
          32'd8:  begin sw = m_led & ~d[LW-1:0]; touch0 = d[0]; end
          32'd12: begin sw = m_led ^ d[LW-1:0];  touch0 = d[0]; end
          32'd16: n_timer = (m_timer & ~mask) | d;
          32'd20: if (mask[0]) begin n_en = d[0]; n_ab = d[1]; end
          32'd24: n_cmp = (m_cmp & ~mask) | d;
          32'd28: if (d[0] && !fire) n_match = 1'b0;
          default: ;
        endcase
        if (off < 32'd16) n_led = {sw[LW-1:1], touch0 ? sw[0] : n_led[0]};
      end
    end
    m_pend  = acc || (m_pend && !bus.rsp_ready);
    m_led   = n_led;  m_timer = n_timer; m_cmp = n_cmp;
    m_en    = n_en;   m_ab    = n_ab;    m_match = n_match;
  endfunction

  // Monitor + model: compare at the falling edge, then step the model for the next edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
      expq.delete();
    end else begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
      check("req_ready", 32'(bus.req_ready), 32'(!m_pend || bus.rsp_ready));
      check("led", 32'(led), 32'(m_led));
      if (bus.rsp_valid) begin
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: got response %h with nothing outstanding (cycle %0d)", bus.rsp_rdata, cyc);
        end else begin
          check("rsp_rdata", bus.rsp_rdata, expq[0].rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(expq[0].err));
          if (bus.rsp_ready) begin
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
            void'(expq.pop_front());
          end
        end
      end
      model_step();
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
      default: bus.rsp_ready = 1'b0;
    endcase
  end

  // Present a request at posedge+1 and hold it until accepted; returns at posedge+1
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    bit done = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wstrb = strb;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      done = (expq.size() == 0);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", expq.size());
    end
  endtask

  task automatic store(input logic [4:0] ofs, input logic [31:0] d, input logic [3:0] strb);
    issue(1'b1, BASE + 32'(ofs), d, strb);
  endtask

  task automatic load_chk(input string name, input logic [4:0] ofs, input logic [31:0] exp);
    issue(1'b0, BASE + 32'(ofs), 32'd0, 4'h0);
    drain();
    check(name, last_rdata, exp);
  endtask

  task automatic wait_timer(input logic [31:0] val);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = (m_timer == val);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timer_wait: timer never reached %h", val);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           tog[$];
    logic         prev;
    logic [LW-1:0] snap;
    logic [31:0]  a, d;
    logic [4:0]   o;
    logic         we;
    model_reset();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = BASE;
    bus.req_wdata = 32'hFFFF_FFFF; bus.req_wstrb = 4'hF; bus.rsp_ready = 1'b0;

    // Reset held with a request pending: nothing accepted, nothing answered
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; rdy_mode = 0; rst_n = 1'b1;
    @(posedge clk); #1;

    load_chk("rst_ctrl", OFS_CTRL, 32'd0);
    load_chk("rst_cmp", OFS_CMP, 32'hFFFF_FFFF);
    load_chk("rst_status", OFS_STATUS, 32'd0);

    // LED write / set / clear / toggle
    store(OFS_LED_OUT, 32'h0000_00A5, 4'hF); drain(); check("led_out", 32'(led), 32'hA5);
    load_chk("rd_out", OFS_LED_OUT, 32'hA5);
    store(OFS_LED_SET, 32'h0000_005A, 4'hF); drain(); check("led_set", 32'(led), 32'hFF);
    load_chk("rd_set", OFS_LED_OUT, 32'hFF);
    store(OFS_LED_CLR, 32'h0000_000F, 4'hF); drain(); check("led_clr", 32'(led), 32'hF0);
    load_chk("rd_clr", OFS_LED_OUT, 32'hF0);
    store(OFS_LED_TGL, 32'h0000_0001, 4'hF); drain(); check("led_tgl", 32'(led), 32'hF1);
    load_chk("rd_tgl", OFS_LED_OUT, 32'hF1);
    load_chk("rd_w1s_reads0", OFS_LED_SET, 32'd0);

    // Response stall: response held, second request blocked until drain
    rdy_mode = 2;
    issue(1'b0, BASE, 32'd0, 4'h0);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = BASE + 32'h10; bus.req_wstrb = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rdata", bus.rsp_rdata, 32'hF1);
      check("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    begin
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk); done = bus.req_ready;
        @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      check("stall_released", 32'(done), 32'd1);
    end
    drain();
    check("stall_second_rd", last_rdata, 32'd0);

    // Autoblink: CMP=4, EN|AUTOBLINK -> led[0] toggles every 5 cycles
    store(OFS_CMP, 32'd4, 4'hF);
    store(OFS_CTRL, 32'd3, 4'hF);
    drain();
    prev = led[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (led[0] != prev) tog.push_back(cyc);
      prev = led[0];
    end
    check("blink_count", 32'(tog.size() >= 7), 32'd1);
    for (int k = 1; k < tog.size(); k++) check("blink_period", 32'(tog[k] - tog[k-1]), 32'd5);
    @(posedge clk); #1;

    // W1C of MATCH on a match edge loses to the hardware set
    wait_timer(32'd4);
    store(OFS_STATUS, 32'd1, 4'h1);
    store(OFS_CTRL, 32'd0, 4'hF);
    load_chk("w1c_on_match", OFS_STATUS, 32'd1);
    store(OFS_STATUS, 32'd1, 4'h1);
    load_chk("w1c_clears", OFS_STATUS, 32'd0);

    // Decode errors have no side effects
    snap = led;
    issue(1'b0, BASE + 32'h20, 32'd0, 4'h0); drain();
    check("err_oob_flag", 32'(last_err), 32'd1);
    check("err_oob_rdata", last_rdata, 32'd0);
    issue(1'b1, BASE + 32'h02, 32'hFFFF_FFFF, 4'hF); drain();
    check("err_misalign_flag", 32'(last_err), 32'd1);
    issue(1'b0, BASE - 32'd4, 32'd0, 4'h0); drain();
    check("err_below_base", 32'(last_err), 32'd1);
    load_chk("err_no_side_effect", OFS_LED_OUT, 32'(snap));

    // SW write to TIMER on a match edge beats the wrap; wstrb masks upper lanes
    store(OFS_TIMER, 32'd0, 4'hF);
    store(OFS_CMP, 32'd4, 4'hF);
    store(OFS_CTRL, 32'd1, 4'hF);
    wait_timer(32'd4);
    store(OFS_TIMER, 32'hAABB_CC64, 4'b0001);
    load_chk("timer_wr_beats_wrap", OFS_TIMER, 32'h64);
    store(OFS_CTRL, 32'd0, 4'hF);
    store(OFS_TIMER, 32'd0, 4'hF);
    load_chk("zero_strb_noop_pre", OFS_TIMER, 32'd0);
    store(OFS_TIMER, 32'h1234_5678, 4'h0);
    load_chk("zero_strb_noop", OFS_TIMER, 32'd0);

    // Randomized traffic with random response backpressure
    rdy_mode = 1;
    for (int n = 0; n < 400; n++) begin
      o  = 5'($urandom_range(0, 7) * 4);
      we = 1'($urandom_range(0, 1));
      d  = $urandom();
      if (o == OFS_TIMER || o == OFS_CMP) d = $urandom_range(0, 12);
      a  = BASE + 32'(o);
      case ($urandom_range(0, 19))
        0: a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
        1: a = a + 32'($urandom_range(1, 3));
        default: ;
      endcase
      issue(we, a, d, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    drain();

    // Reset in the middle of a stalled transaction drops the response
    store(OFS_LED_OUT, 32'h3C, 4'hF);
    rdy_mode = 2;
    issue(1'b0, BASE, 32'd0, 4'h0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_led", 32'(led), 32'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    load_chk("midrst_led_rd", OFS_LED_OUT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
